sram_readout: RTL and testbench

SRAM_READOUT -- requirements
Module: sram_readout

---
 rtl/sram_readout_pkg.sv | 19 +
 rtl/sram_rd_fifo.sv | 56 +++++
 rtl/sram_readout.sv | 124 ++++++++++++
 tb/tb_sram_readout.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_readout_pkg.sv
// Shared SRAM constants and readout state encoding.
// The SRAM writer imports the same package, so the SRAM geometry is defined in one place.
package sram_readout_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    // Constants owned by the SRAM writer side of the shared memory
    localparam logic [SRAM_DW-1:0] WR_SYNC_WORD  = 16'hEB90;
    localparam logic [SRAM_AW-1:0] WR_MAX_WORDS  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Output skid FIFO between the SRAM capture pipeline and the host link.
// The head word reads as zero while the FIFO is empty.
module sram_rd_fifo
    import sram_readout_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [SRAM_DW-1:0] push_data_i,
    input  logic               pop_i,
    output logic [SRAM_DW-1:0] head_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SRAM_DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_pop = pop_i && (r_count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(push_i) - CW'(w_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr] <= push_data_i;
    end

    assign empty_o = (r_count == '0);
    assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/sram_readout.sv
// Streams a captured record out of SRAM to the host link through a credit-limited
// read pipeline and a skid FIFO; ping_i or reset abandons the readout.
module sram_readout
    import sram_readout_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ping_i,
    input  logic               packet_formed_i,
    input  logic               forming_packet_i,
    input  logic [SRAM_AW-1:0] total_words_i,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_rd_n,
    input  logic [SRAM_DW-1:0] sram_q,
    output logic [SRAM_DW-1:0] tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rd_state_e               r_state, w_next_state;
    logic                    r_pf, r_armed, r_rd_n, r_done;
    logic [SRAM_AW-1:0]      r_remaining, r_rd_ptr, r_addr;
    logic [READ_LATENCY-1:0] r_vld;
    logic [CW-1:0]           r_in_flight, w_fifo_count;
    logic [CW:0]             w_outstanding;
    logic                    w_fifo_empty, w_start, w_strobe, w_flush, w_push, w_pop, w_credit;

    // Armed only after packet_formed_i has been seen low, so a level held through reset cannot start.
    assign w_start = (r_state == ST_IDLE) && r_armed && !r_pf && packet_formed_i
                     && !forming_packet_i && !ping_i;

    assign w_outstanding = {1'b0, r_in_flight} + {1'b0, w_fifo_count};
    assign w_credit      = w_outstanding < (CW + 1)'(FIFO_DEPTH);
    assign w_push        = r_vld[READ_LATENCY-1];
    assign w_pop         = tx_valid_o && tx_ready_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_strobe     = 1'b0;
        w_flush      = 1'b0;
        if (ping_i && r_state != ST_IDLE) begin
            w_next_state = ST_IDLE;
            w_flush      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start) w_next_state = (total_words_i == '0) ? ST_DONE : ST_READ;
                ST_READ:  if (w_credit) begin
                              w_strobe = 1'b1;
                              if (r_remaining == SRAM_AW'(1)) w_next_state = ST_DRAIN;
                          end
                ST_DRAIN: if (r_in_flight == '0 && w_fifo_empty) w_next_state = ST_DONE;
                ST_DONE:  w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_pf        <= 1'b0;
            r_armed     <= 1'b0;
            r_rd_n      <= 1'b1;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_rd_ptr    <= '0;
            r_addr      <= '0;
            r_vld       <= '0;
            r_in_flight <= '0;
        end else begin
            r_state <= w_next_state;
            r_pf    <= packet_formed_i;
            if (!packet_formed_i) r_armed <= 1'b1;
            r_rd_n  <= !w_strobe;
            r_done  <= (r_state == ST_DONE) && !ping_i;
            // The valid pipe starts one cycle after the strobe, lining up with sram_q.
            if (w_flush) begin
                r_vld       <= '0;
                r_in_flight <= '0;
            end else begin
                r_vld       <= (r_vld << 1) | READ_LATENCY'(!r_rd_n);
                r_in_flight <= r_in_flight + CW'(w_strobe) - CW'(w_push);
            end
            if (w_start) begin
                r_remaining <= total_words_i;
                r_rd_ptr    <= '0;
                r_addr      <= '0;
            end else if (w_strobe) begin
                r_addr      <= r_rd_ptr;
                r_rd_ptr    <= r_rd_ptr + SRAM_AW'(1);
                r_remaining <= r_remaining - SRAM_AW'(1);
            end
        end
    end

    sram_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (w_flush),
        .push_i      (w_push),
        .push_data_i (sram_q),
        .pop_i       (w_pop),
        .head_o      (tx_data_o),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    assign tx_valid_o = !w_fifo_empty;
    assign sram_addr  = r_addr;
    assign sram_rd_n  = r_rd_n;
    assign busy_o     = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done_o     = r_done;

endmodule

// File: tb/tb_sram_readout.sv
// Self-checking bench for sram_readout: SRAM model, stream scoreboard and directed scenarios.
module tb_sram_readout;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ping_i = 1'b0;
    logic        packet_formed_i = 1'b0;
    logic        forming_packet_i = 1'b0;
    logic [19:0] total_words_i = '0;
    logic [19:0] sram_addr;
    logic        sram_rd_n;
    logic [15:0] sram_q = 16'hDEAD;
    logic [15:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    sram_readout #(.READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ping_i           (ping_i),
        .packet_formed_i  (packet_formed_i),
        .forming_packet_i (forming_packet_i),
        .total_words_i    (total_words_i),
        .sram_addr        (sram_addr),
        .sram_rd_n        (sram_rd_n),
        .sram_q           (sram_q),
        .tx_data_o        (tx_data_o),
        .tx_valid_o       (tx_valid_o),
        .tx_ready_i       (tx_ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Memory contents as a pure function of address.
    function automatic logic [15:0] sram_word(input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo ^ 8'hA5, lo};
    endfunction

    // SRAM: a strobe during cycle c yields its word on sram_q during cycle c+LAT (LAT=2).
    logic        m_v1 = 1'b0;
    logic [19:0] m_a1 = '0;
    always @(posedge clk_i) begin
        m_v1  <= !sram_rd_n;
        m_a1  <= sram_addr;
        sram_q <= m_v1 ? sram_word(int'(m_a1)) : 16'hDEAD;
    end

    int ready_mode = 0;
    int cyc = 0;
    always @(posedge clk_i) begin
        cyc++;
        #1;
        tx_ready_i = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Scoreboard state
    int          exp_idx = 0, strobe_idx = 0, done_cnt = 0;
    bit          busy_seen = 0, stall_prev = 0;
    logic [15:0] stall_data = '0, first_word = '0, last_word = '0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_prev = 0;
        end else begin
            if (busy_o) busy_seen = 1;
            if (!sram_rd_n) begin
                check("strobe_addr", sram_addr, strobe_idx);
                check("credit_bound", (strobe_idx + 1 - exp_idx) <= DEPTH, 1);
                strobe_idx++;
            end
            if (stall_prev) begin
                check("stall_valid", tx_valid_o, 1);
                check("stall_data", tx_data_o, stall_data);
            end
            if (tx_valid_o && tx_ready_i) begin
                check("tx_data", tx_data_o, sram_word(exp_idx));
                if (exp_idx == 0) first_word = tx_data_o;
                last_word = tx_data_o;
                exp_idx++;
            end
            stall_prev = tx_valid_o && !tx_ready_i;
            stall_data = tx_data_o;
            if (done_o) begin
                done_cnt++;
                check("busy_at_done", busy_o, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_model();
        exp_idx = 0; strobe_idx = 0; done_cnt = 0; busy_seen = 0; stall_prev = 0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int k = 0; k < bound && done_cnt == 0; k++) tick(1);
        check({name, "_done_seen"}, done_cnt > 0, 1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_rd_n"}, sram_rd_n, 1);
        check({name, "_addr"}, sram_addr, 0);
        check({name, "_valid"}, tx_valid_o, 0);
        check({name, "_data"}, tx_data_o, 0);
        check({name, "_busy"}, busy_o, 0);
        check({name, "_done"}, done_o, 0);
    endtask

    task automatic run_full(input string name, input int n, input int mode);
        clear_model();
        ready_mode      = mode;
        total_words_i   = 20'(n);
        packet_formed_i = 1'b1;
        wait_done(name, 50 * n + 50);
        tick(3);
        check({name, "_words"}, exp_idx, n);
        check({name, "_strobes"}, strobe_idx, n);
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_busy_after"}, busy_o, 0);
        packet_formed_i = 1'b0;
        ready_mode      = 0;
        tick(2);
    endtask

    initial begin
        int s;
        tick(3);
        check_reset_values("reset");
        rst_i = 1'b0;
        tick(2);

        // Full-rate readout of 52 words
        run_full("w52", 52, 0);
        check("w52_first", first_word, 16'hA500);
        check("w52_last", last_word, 16'h9633);

        // Throttled host, with a second packet_formed edge while busy
        clear_model();
        ready_mode      = 1;
        total_words_i   = 20'd10;
        packet_formed_i = 1'b1;
        tick(6);
        packet_formed_i = 1'b0;
        tick(2);
        packet_formed_i = 1'b1;
        check("w10_busy_mid", busy_o, 1);
        wait_done("w10", 400);
        tick(3);
        check("w10_words", exp_idx, 10);
        check("w10_strobes", strobe_idx, 10);
        check("w10_done_cnt", done_cnt, 1);
        check("w10_last", last_word, 16'hAC09);
        packet_formed_i = 1'b0;
        ready_mode      = 0;
        tick(2);

        // Zero-length record: done two cycles after the edge, nothing read
        clear_model();
        total_words_i   = 20'd0;
        packet_formed_i = 1'b1;
        @(negedge clk_i); check("w0_done_c0", done_o, 0);
        @(negedge clk_i); check("w0_done_c1", done_o, 0);
        @(negedge clk_i); check("w0_done_c2", done_o, 1);
        @(negedge clk_i); check("w0_done_c3", done_o, 0);
        tick(2);
        check("w0_strobes", strobe_idx, 0);
        check("w0_busy_seen", busy_seen, 0);
        check("w0_done_cnt", done_cnt, 1);
        packet_formed_i = 1'b0;
        tick(2);

        // Edge while the writer owns the SRAM
        clear_model();
        forming_packet_i = 1'b1;
        total_words_i    = 20'd8;
        packet_formed_i  = 1'b1;
        tick(10);
        forming_packet_i = 1'b0;
        tick(5);
        check("forming_strobes", strobe_idx, 0);
        check("forming_busy_seen", busy_seen, 0);
        check("forming_done_cnt", done_cnt, 0);
        packet_formed_i = 1'b0;
        tick(2);

        // Ping at word 20 of 52
        clear_model();
        total_words_i   = 20'd52;
        packet_formed_i = 1'b1;
        for (int k = 0; k < 300 && exp_idx < 20; k++) tick(1);
        check("ping_reached_20", exp_idx >= 20, 1);
        ping_i = 1'b1;
        tick(1);
        ping_i = 1'b0;
        check("ping_valid_next", tx_valid_o, 0);
        check("ping_busy_next", busy_o, 0);
        s = strobe_idx;
        tick(15);
        check("ping_no_strobe", strobe_idx, s);
        check("ping_no_done", done_cnt, 0);
        check("ping_valid_later", tx_valid_o, 0);
        packet_formed_i = 1'b0;
        tick(2);
        run_full("after_ping", 12, 0);

        // Reset at word 5 with packet_formed_i held high
        clear_model();
        total_words_i   = 20'd52;
        packet_formed_i = 1'b1;
        for (int k = 0; k < 300 && exp_idx < 5; k++) tick(1);
        check("rst_reached_5", exp_idx >= 5, 1);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check_reset_values("midrst");
        s = strobe_idx;
        busy_seen = 0;
        tick(12);
        check("midrst_no_strobe", strobe_idx, s);
        check("midrst_no_busy", busy_seen, 0);
        check("midrst_no_done", done_cnt, 0);
        packet_formed_i = 1'b0;
        tick(2);
        run_full("after_rst", 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
